// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with fixed request-to-response latency
// Byte/half/word little-endian lanes; the store commits on the edge that enters RESP.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h01000000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] address,
  input  logic        read_write,
  input  logic [1:0]  access_size,
  input  logic        load_unsigned,
  input  logic [31:0] data_in,
  output logic        resp_valid,
  output logic [31:0] data_out,
  output logic        error
);

  localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q;
  logic        rw_q, uns_q;
  logic [1:0]  size_q;
  logic [31:0] data_out_q, data_out_d;
  logic        error_q, error_d;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic [31:0]   offset;
  logic [AW-1:0] idx;
  logic          misalign, acc_err, commit, accept;
  logic [31:0]   rd_word, load_val, wr_data;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [3:0]    wr_be;

  assign accept   = (state_q == S_IDLE) && req_valid;
  assign offset   = addr_q - BASE_ADDR;
  assign idx      = offset[AW+1:2];
  assign misalign = ((size_q == SZ_HALF) && addr_q[0]) ||
                    ((size_q == SZ_WORD) && (addr_q[1:0] != 2'b00));
  assign acc_err  = (offset >= SPAN) || (size_q == 2'b11) || misalign;
  assign commit   = (state_q == S_WAIT) && (cnt_q == 4'd0);

  assign rd_word  = mem_q[idx];
  assign half_sel = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    byte_sel = rd_word[7:0];
    case (addr_q[1:0])
      2'd1:    byte_sel = rd_word[15:8];
      2'd2:    byte_sel = rd_word[23:16];
      2'd3:    byte_sel = rd_word[31:24];
      default: byte_sel = rd_word[7:0];
    endcase
  end

  always_comb begin
    load_val = rd_word;
    wr_be    = 4'b1111;
    wr_data  = wdata_q;
    case (size_q)
      SZ_BYTE: begin
        load_val = {{24{~uns_q & byte_sel[7]}}, byte_sel};
        wr_be    = 4'b0001 << addr_q[1:0];
        wr_data  = {4{wdata_q[7:0]}};
      end
      SZ_HALF: begin
        load_val = {{16{~uns_q & half_sel[15]}}, half_sel};
        wr_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        wr_data  = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_out_d = data_out_q;
    error_d    = error_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        state_d = S_WAIT;
        cnt_d   = CNT_INIT;
      end
      S_WAIT: if (cnt_q == 4'd0) begin
        state_d    = S_RESP;
        data_out_d = (acc_err || rw_q) ? 32'd0 : load_val;
        error_d    = acc_err;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rw_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= 2'b00;
      data_out_q <= 32'd0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      error_q    <= error_d;
      if (accept) begin
        addr_q  <= address;
        wdata_q <= data_in;
        rw_q    <= read_write;
        uns_q   <= load_unsigned;
        size_q  <= access_size;
      end
    end
  end

  // commit only fires from WAIT, so an asserted reset (which forces IDLE) blocks it
  always_ff @(posedge clock) begin
    if (commit && rw_q && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem_q[idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign data_out   = data_out_q;
  assign error      = error_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
// Directed vector table, byte-level reference model with random traffic, reset and handshake sequences.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h01000000;
  localparam int unsigned LAT   = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] address = 32'd0;
  logic        read_write = 1'b0;
  logic [1:0]  access_size = 2'b00;
  logic        load_unsigned = 1'b0;
  logic [31:0] data_in = 32'd0;
  logic        resp_valid;
  logic [31:0] data_out;
  logic        error;

  int checks = 0;
  int errors = 0;

  logic [7:0] mdl [DEPTH*4];

  typedef struct {
    logic        rw;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_d;
    logic        exp_e;
  } vec_t;

  vec_t tbl[$];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .address(address), .read_write(read_write), .access_size(access_size),
    .load_unsigned(load_unsigned), .data_in(data_in), .resp_valid(resp_valid),
    .data_out(data_out), .error(error)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Reference semantics at byte granularity: error rules, little-endian assembly, two's-complement extension
  task automatic model_exec(input logic rw, input logic [1:0] sz, input logic uns,
                            input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] exp_d, output logic exp_e);
    logic [31:0] off;
    logic [31:0] v;
    logic [31:0] t;
    int n;
    n     = 1 << sz;
    off   = a - BASE;
    exp_e = (sz == 2'b11) || (off >= DEPTH*4) || ((a % n) != 0);
    exp_d = 32'd0;
    if (!exp_e) begin
      if (rw) begin
        for (int i = 0; i < n; i++) begin
          t = d >> (8*i);
          mdl[off + i] = t[7:0];
        end
      end else begin
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(mdl[off + i]) << (8*i));
        if (!uns && n < 4 && v[8*n-1]) v = v - (32'd1 << (8*n));
        exp_d = v;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic rw, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] got_d, output logic got_e);
    int lat;
    bit ready_low;
    logic [31:0] held;
    @(negedge clock);
    chk({tag, " ready_before"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; read_write = rw; access_size = sz; load_unsigned = uns;
    address = a; data_in = d;
    @(posedge clock);
    lat = 99; ready_low = 1'b1; got_d = 32'hx; got_e = 1'bx;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (k == 1) begin
        req_valid = 1'b0; address = $urandom; data_in = $urandom;
        read_write = ~rw; access_size = $urandom_range(0, 3);
      end
      if (req_ready) ready_low = 1'b0;
      if (resp_valid) begin
        got_d = data_out; got_e = error; lat = k;
        break;
      end
    end
    chk({tag, " latency"}, 32'(lat), 32'(LAT + 1));
    chk({tag, " ready_low"}, 32'(ready_low), 32'd1);
    held = data_out;
    @(negedge clock);
    chk({tag, " resp_pulse"}, 32'(resp_valid), 32'd0);
    chk({tag, " hold"}, data_out, held);
  endtask

  function automatic vec_t mk(input logic rw, input logic [1:0] sz, input logic uns,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] ed, input logic ee);
    vec_t v;
    v.rw = rw; v.sz = sz; v.uns = uns; v.a = a; v.d = d; v.exp_d = ed; v.exp_e = ee;
    return v;
  endfunction

  initial begin
    logic [31:0] gd, md;
    logic ge, me;
    vec_t hs[3];
    int acc_cyc[3];
    int nacc;
    logic [31:0] rd_q[$];
    logic re_q[$];
    int stray;

    tbl.push_back(mk(1, 2'b10, 0, 32'h01000010, 32'hDEADBEEF, 32'h0, 0));
    tbl.push_back(mk(0, 2'b10, 0, 32'h01000010, 32'h0, 32'hDEADBEEF, 0));
    tbl.push_back(mk(1, 2'b10, 0, 32'h01000010, 32'h11223344, 32'h0, 0));
    tbl.push_back(mk(1, 2'b00, 0, 32'h01000013, 32'h000000A5, 32'h0, 0));
    tbl.push_back(mk(0, 2'b10, 0, 32'h01000010, 32'h0, 32'hA5223344, 0));
    tbl.push_back(mk(0, 2'b00, 0, 32'h01000013, 32'h0, 32'hFFFFFFA5, 0));
    tbl.push_back(mk(0, 2'b00, 1, 32'h01000013, 32'h0, 32'h000000A5, 0));
    tbl.push_back(mk(1, 2'b01, 0, 32'h01000012, 32'h00008001, 32'h0, 0));
    tbl.push_back(mk(0, 2'b10, 0, 32'h01000010, 32'h0, 32'h80013344, 0));
    tbl.push_back(mk(0, 2'b01, 0, 32'h01000012, 32'h0, 32'hFFFF8001, 0));
    tbl.push_back(mk(0, 2'b01, 1, 32'h01000012, 32'h0, 32'h00008001, 0));
    tbl.push_back(mk(0, 2'b01, 0, 32'h01000010, 32'h0, 32'h00003344, 0));
    tbl.push_back(mk(1, 2'b10, 0, 32'h01000000, 32'hCAFEF00D, 32'h0, 0));
    tbl.push_back(mk(0, 2'b10, 0, 32'h01000002, 32'h0, 32'h0, 1));
    tbl.push_back(mk(1, 2'b01, 0, 32'h01000001, 32'h0000FFFF, 32'h0, 1));
    tbl.push_back(mk(0, 2'b10, 0, BASE + DEPTH*4, 32'h0, 32'h0, 1));
    tbl.push_back(mk(0, 2'b10, 0, 32'h00FFFFFC, 32'h0, 32'h0, 1));
    tbl.push_back(mk(1, 2'b11, 0, 32'h01000010, 32'hFFFFFFFF, 32'h0, 1));
    tbl.push_back(mk(0, 2'b11, 0, 32'h01000010, 32'h0, 32'h0, 1));
    tbl.push_back(mk(0, 2'b10, 0, 32'h01000000, 32'h0, 32'hCAFEF00D, 0));
    tbl.push_back(mk(0, 2'b10, 0, 32'h01000010, 32'h0, 32'h80013344, 0));

    #1;
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset data_out", data_out, 32'd0);
    chk("reset error", 32'(error), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].rw, tbl[i].sz, tbl[i].uns, tbl[i].a, tbl[i].d, gd, ge);
      model_exec(tbl[i].rw, tbl[i].sz, tbl[i].uns, tbl[i].a, tbl[i].d, md, me);
      chk($sformatf("vec%0d data", i), gd, tbl[i].exp_d);
      chk($sformatf("vec%0d err", i), 32'(ge), 32'(tbl[i].exp_e));
    end

    // Reset pulse during WAIT must drop the uncommitted store
    run_op("rst_pre_sw", 1, 2'b10, 0, 32'h01000020, 32'h0BADC0DE, gd, ge);
    model_exec(1, 2'b10, 0, 32'h01000020, 32'h0BADC0DE, md, me);
    run_op("rst_pre_lw", 0, 2'b10, 0, 32'h01000020, 32'h0, gd, ge);
    chk("rst_pre_lw data", gd, 32'h0BADC0DE);
    @(negedge clock);
    req_valid = 1'b1; read_write = 1'b1; access_size = 2'b10;
    address = 32'h01000020; data_in = 32'h12345678;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_mid req_ready", 32'(req_ready), 32'd1);
    chk("rst_mid resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mid data_out", data_out, 32'd0);
    chk("rst_mid error", 32'(error), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    stray = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (resp_valid) stray++;
    end
    chk("rst_mid stray_resp", 32'(stray), 32'd0);
    run_op("rst_post_lw", 0, 2'b10, 0, 32'h01000020, 32'h0, gd, ge);
    chk("rst_post_lw data", gd, 32'h0BADC0DE);
    chk("rst_post_lw err", 32'(ge), 32'd0);

    // Held req_valid: three accepts with garbage inputs between them
    hs[0] = mk(1, 2'b10, 0, 32'h01000030, 32'hAABBCCDD, 32'h0, 0);
    hs[1] = mk(0, 2'b01, 1, 32'h01000032, 32'h0, 32'h0000AABB, 0);
    hs[2] = mk(0, 2'b00, 0, 32'h01000030, 32'h0, 32'hFFFFFFDD, 0);
    nacc = 0;
    for (int k = 0; k < 100 && rd_q.size() < 3; k++) begin
      @(negedge clock);
      if (resp_valid) begin
        rd_q.push_back(data_out);
        re_q.push_back(error);
      end
      if (req_ready && nacc < 3) begin
        req_valid = 1'b1; read_write = hs[nacc].rw; access_size = hs[nacc].sz;
        load_unsigned = hs[nacc].uns; address = hs[nacc].a; data_in = hs[nacc].d;
        acc_cyc[nacc] = k;
        nacc++;
      end else if (req_ready) begin
        req_valid = 1'b0;
      end else begin
        address = $urandom; data_in = $urandom; read_write = $urandom_range(0, 1);
        access_size = $urandom_range(0, 3); load_unsigned = $urandom_range(0, 1);
      end
    end
    req_valid = 1'b0;
    chk("hs accepts", 32'(nacc), 32'd3);
    chk("hs responses", 32'(rd_q.size()), 32'd3);
    if (nacc == 3) begin
      chk("hs spacing01", 32'(acc_cyc[1] - acc_cyc[0]), 32'(LAT + 2));
      chk("hs spacing12", 32'(acc_cyc[2] - acc_cyc[1]), 32'(LAT + 2));
    end
    for (int i = 0; i < 3 && i < rd_q.size(); i++) begin
      model_exec(hs[i].rw, hs[i].sz, hs[i].uns, hs[i].a, hs[i].d, md, me);
      chk($sformatf("hs%0d data", i), rd_q[i], hs[i].exp_d);
      chk($sformatf("hs%0d err", i), 32'(re_q[i]), 32'(hs[i].exp_e));
    end
    repeat (3) @(negedge clock);

    // Random traffic against the byte-level model over a 64-byte window
    for (int w = 0; w < 16; w++) begin
      logic [31:0] a, d;
      a = BASE + 32'(w * 4);
      d = $urandom;
      run_op("init", 1, 2'b10, 0, a, d, gd, ge);
      model_exec(1, 2'b10, 0, a, d, md, me);
    end
    for (int i = 0; i < 150; i++) begin
      logic rw, uns;
      logic [1:0] sz;
      logic [31:0] a, d;
      int r;
      rw  = $urandom_range(0, 1);
      uns = $urandom_range(0, 1);
      r   = $urandom_range(0, 9);
      sz  = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      a   = BASE + $urandom_range(0, 63);
      if ($urandom_range(0, 9) == 0) a = $urandom;
      if ($urandom_range(0, 1) == 1 && sz != 2'b11) a = a & ~((32'd1 << sz) - 32'd1);
      d = $urandom;
      run_op($sformatf("rnd%0d", i), rw, sz, uns, a, d, gd, ge);
      model_exec(rw, sz, uns, a, d, md, me);
      chk($sformatf("rnd%0d data a=%h sz=%0d rw=%0d", i, a, sz, rw), gd, md);
      chk($sformatf("rnd%0d err a=%h sz=%0d", i, a, sz), 32'(ge), 32'(me));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
